fixed_float_conv_sched: RTL and testbench
=========================================

# fixed_float_conv_sched

Round-robin scheduler that shares one fixed-to-float converter (22-bit fixed point to IEEE-754 single) between `NUM_REQ` requesters. It sits between the requester-side valid/ready ports and the converter's `enable`/`data`/`done`/`result` port. It serialises requests, sequences each conversion, guards against a missing `done` with a timeout, and returns each tagged result through a valid/ready response port.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `TIMEOUT`, default 15: maximum cycles in WAIT before the conversion is abandoned, ≥1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_data` in 22·NUM_REQ: requester i occupies bits [22i+21:22i] (1 sign, 1 integer, 20 fraction bits).
- `req_ready` out NUM_REQ: one-hot grant; handshake occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: response valid.
- `rsp_id` out clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_result` out 32: float result.
- `rsp_err` out 1: high when the conversion timed out.
- `rsp_ready` in 1: response consumer ready.
- `conv_enable` out 1: one-cycle start pulse to the converter.
- `conv_data` out 22: registered operand, stable from ISSUE until the next accept.
- `conv_done` in 1: converter completion pulse.
- `conv_result` in 32: converter output, valid while `conv_done` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - The arbiter grants the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - `req_ready` is asserted combinationally for that requester only.
  - On handshake: latch data into `conv_data` and the index into `rsp_id`; set `rr_ptr` = grant+1 mod NUM_REQ; go to ISSUE.
- ISSUE: `conv_enable`=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - If `conv_done`: latch `conv_result`, set `rsp_err`=0, go to RESP.
  - Otherwise the timer increments. When the timer equals TIMEOUT-1 and `conv_done` is still low: set `rsp_result`=0, set `rsp_err`=1, go to RESP.
  - WAIT therefore lasts at most TIMEOUT cycles.
- RESP: `rsp_valid`=1, with id, result and err held stable. On `rsp_ready` go to IDLE.
- `req_ready` is all-zero in every state except IDLE. No request is accepted while a conversion is in flight.
- `conv_done` is ignored outside WAIT.
- A requester may drop `req_valid` before it is granted; nothing is accepted and the pointer does not move.
- Timer width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, timer 0.
- Outputs under reset: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`, `conv_enable` and `conv_data` are all 0.
- Reset mid-operation abandons the in-flight conversion. No response is emitted, and a late `conv_done` is ignored.
- Latency with a converter that raises `done` one cycle after `enable`:
  - accept at edge E0;
  - `conv_enable` high during E0→E1;
  - `conv_done` high during E1→E2;
  - `rsp_valid` high from E2.
  - Total: 2 edges from accept to response.
- Minimum spacing between accepts is 4 cycles (IDLE, ISSUE, WAIT, RESP with `rsp_ready` held high).
- If `conv_done` arrives in the final WAIT cycle (timer = TIMEOUT-1), `done` wins: result is captured and err=0.
- If `rsp_ready` is high on the first RESP cycle, RESP lasts exactly one cycle. New arbitration starts in the following IDLE cycle.

## Structure
- Shared package `fixed_float_pkg`:
  - `FIXED_W`=22 and `FLOAT_W`=32;
  - FSM state enum `sched_state_t`.
  - Later conversion blocks import the same package.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req[N]`, `ptr`;
  - outputs one-hot `grant`, `grant_idx` and `any`;
  - purely combinational.
- The scheduler owns `rr_ptr`, the FSM, the timer and the operand/response registers.

## Test plan
- Single request, bench converter with 1-cycle done: requester 0, data 22'h100000 (+1.0) → `rsp_id`=0, `rsp_result`=32'h3F800000, `rsp_err`=0, `rsp_valid` 2 edges after accept.
- All four requesters valid continuously from reset: grant order 0,1,2,3,0; data 22'h300000 on requester 2 → 32'hBF800000 with `rsp_id`=2.
- Backpressure: `rsp_ready` low for 5 cycles in RESP → response fields stable, `req_ready` all-zero, nothing accepted; accept resumes the cycle after the RESP handshake.
- Timeout, TIMEOUT=15, converter never responds: `rsp_valid` with `rsp_err`=1 and `rsp_result`=0 after exactly 15 WAIT cycles.
- `conv_done` in WAIT cycle 15 (TIMEOUT=15) → `rsp_err`=0 and `conv_result` captured.
- `rst` asserted in WAIT, then `conv_done` pulses after reset → no response; the next request from requesters 1 and 0 grants 0 first (pointer reset).

Source files
------------

// File: rtl/fixed_float_pkg.sv
// Shared types and widths for the fixed/float conversion blocks.
// The scheduler and any later conversion stages import this package.
package fixed_float_pkg;

    localparam int FIXED_W = 22;
    localparam int FLOAT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/fixed_float_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// at or above ptr, wrapping past N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a variable unassigned and infers a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fixed_float_conv_sched.sv
// Round-robin scheduler sharing one fixed-to-float converter between
// NUM_REQ requesters, with a done timeout and a tagged response port.
module fixed_float_conv_sched
    import fixed_float_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [FIXED_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [FLOAT_W-1:0]           rsp_result,
    output logic                         rsp_err,
    input  logic                         rsp_ready,
    output logic                         conv_enable,
    output logic [FIXED_W-1:0]           conv_data,
    input  logic                         conv_done,
    input  logic [FLOAT_W-1:0]           conv_result
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [TMR_W-1:0]   timer;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [FIXED_W-1:0] grant_data;
    logic               accept;
    logic               timeout_hit;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // req_ready equals the grant, so a grant in IDLE is already a handshake.
    assign accept      = (state == IDLE) && grant_any;
    assign timeout_hit = (timer == TMR_LAST);

    assign req_ready   = (state == IDLE && !rst) ? grant : '0;
    assign rsp_valid   = (state == RESP) && !rst;
    assign conv_enable = (state == ISSUE) && !rst;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_data = req_data[i*FIXED_W +: FIXED_W];
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (conv_done || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            timer      <= '0;
            conv_data  <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        conv_data <= grant_data;
                        rsp_id    <= grant_idx;
                        rr_ptr    <= (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // A done in the last WAIT cycle still wins over the timeout.
                    if (conv_done) begin
                        rsp_result <= conv_result;
                        rsp_err    <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_float_conv_sched.sv
// Self-checking bench for fixed_float_conv_sched: directed corner cases,
// a vector table, and a randomized run against a transaction-level model.
module tb_fixed_float_conv_sched;

    localparam int N  = 4;
    localparam int T  = 15;
    localparam int FW = 22;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [FW*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_err;
    logic            rsp_ready = 1'b0;
    logic            conv_enable;
    logic [FW-1:0]   conv_data;
    logic            conv_done = 1'b0;
    logic [31:0]     conv_result = '0;

    int total = 0;
    int bad   = 0;

    // Bench converter: raises done conv_delay cycles after the enable cycle;
    // conv_delay = 0 means it never answers.
    int          conv_delay = 1;
    int          conv_cnt   = 0;
    logic [FW-1:0] conv_op  = '0;

    always #5 clk = ~clk;

    fixed_float_conv_sched #(
        .NUM_REQ(N),
        .TIMEOUT(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready),
        .conv_enable (conv_enable),
        .conv_data   (conv_data),
        .conv_done   (conv_done),
        .conv_result (conv_result)
    );

    // Exact conversion of 1.1.20 two's complement to IEEE-754 single.
    function automatic logic [31:0] fix2float(input logic [FW-1:0] x);
        logic [22:0] m;
        logic [46:0] t;
        logic [7:0]  ev;
        int          p;
        m = x[21] ? (23'h400000 - {1'b0, x}) : {1'b0, x};
        if (m == '0) return 32'h0;
        p = 0;
        for (int b = 0; b < 23; b++) if (m[b]) p = b;
        ev = 8'(127 + p - 20);
        t  = 47'(m) << (23 - p);
        return {x[21], ev, t[22:0]};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    function automatic int oh_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        conv_done = 1'b0;
        if (conv_cnt > 0) begin
            conv_cnt = conv_cnt - 1;
            if (conv_cnt == 0) begin
                conv_done   = 1'b1;
                conv_result = fix2float(conv_op);
            end
        end
        if (conv_enable && conv_delay > 0) begin
            conv_cnt = conv_delay;
            conv_op  = conv_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [FW-1:0] d);
        req_data[i*FW +: FW] = d;
        req_valid[i] = 1'b1;
    endtask

    // Returns one cycle after the handshake edge (the ISSUE cycle).
    task automatic wait_accept(input int i, input string name);
        int n;
        n = 0;
        #1;
        while (!req_ready[i] && n < 40) begin
            step();
            #1;
            n++;
        end
        check({name, " accepted"}, 32'(req_ready[i]), 32'd1);
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            step();
            edges++;
        end
    endtask

    typedef struct {
        int            idx;
        logic [FW-1:0] data;
        int            delay;
        logic [31:0]   result;
        logic          err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            gl[$];
        int            gcyc[$];
        int            rid[$];
        int            rcyc[$];
        logic [31:0]   rres[$];
        int            e;
        int            seen;
        int            exp_order[5];
        // random-phase model state
        logic [N-1:0]  pend;
        logic [FW-1:0] pdata[N];
        bit            idle;
        int            ptr, due, cur_id, cur_d, w, g;
        logic [FW-1:0] cur_data;
        bit            exp_rv;

        vecs[0] = '{0, 22'h100000, 1,  32'h3F800000, 1'b0};
        vecs[1] = '{2, 22'h300000, 1,  32'hBF800000, 1'b0};
        vecs[2] = '{1, 22'h080000, 1,  32'h3F000000, 1'b0};
        vecs[3] = '{3, 22'h000000, 3,  32'h00000000, 1'b0};
        vecs[4] = '{1, 22'h200000, 2,  32'hC0000000, 1'b0};
        vecs[5] = '{3, 22'h000001, 1,  32'h35800000, 1'b0};
        vecs[6] = '{2, 22'h1FFFFF, 7,  32'h3FFFFFF8, 1'b0};
        vecs[7] = '{0, 22'h100000, 15, 32'h3F800000, 1'b0};
        vecs[8] = '{1, 22'h100000, 0,  32'h00000000, 1'b1};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state with every requester asking.
        req_data[0*FW +: FW] = 22'h100000;
        req_data[1*FW +: FW] = 22'h080000;
        req_data[2*FW +: FW] = 22'h300000;
        req_data[3*FW +: FW] = 22'h000001;
        req_valid = '1;
        rsp_ready = 1'b1;
        conv_delay = 1;
        repeat (3) step();
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset conv_enable", 32'(conv_enable), 32'h0);
        check("reset conv_data", 32'(conv_data), 32'h0);
        check("reset rsp_id", 32'(rsp_id), 32'h0);
        check("reset rsp_result", rsp_result, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'h0);

        // All four valid continuously from reset.
        rst = 1'b0;
        #1;
        for (int c = 0; c < 80 && rid.size() < 5; c++) begin
            if (req_ready != '0) begin
                gl.push_back(oh_index(req_ready));
                gcyc.push_back(c);
            end
            if (rsp_valid) begin
                rid.push_back(int'(rsp_id));
                rres.push_back(rsp_result);
                rcyc.push_back(c);
            end
            step();
            #1;
        end
        req_valid = '0;
        check("rr grant count", 32'(gl.size() >= 5), 32'd1);
        check("rr response count", 32'(rid.size() >= 5), 32'd1);
        if (gl.size() >= 5 && rid.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rr grant %0d", i), 32'(gl[i]), 32'(exp_order[i]));
                check($sformatf("rr rsp_id %0d", i), 32'(rid[i]), 32'(exp_order[i]));
            end
            for (int i = 1; i < 5; i++)
                check($sformatf("rr accept spacing %0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd4);
            check("rr first latency", 32'(rcyc[0] - gcyc[0]), 32'd3);
            check("rr req2 result", rres[2], 32'hBF800000);
        end
        repeat (20) step();

        // Vector table: one requester at a time, rsp_ready high.
        for (int v = 0; v < 9; v++) begin
            set_req(vecs[v].idx, vecs[v].data);
            conv_delay = vecs[v].delay;
            rsp_ready  = 1'b1;
            wait_accept(vecs[v].idx, $sformatf("tbl%0d", v));
            wait_rsp(e);
            check($sformatf("tbl%0d latency", v), 32'(e),
                  32'(1 + ((vecs[v].delay == 0) ? T : vecs[v].delay)));
            check($sformatf("tbl%0d rsp_id", v), 32'(rsp_id), 32'(vecs[v].idx));
            check($sformatf("tbl%0d rsp_result", v), rsp_result, vecs[v].result);
            check($sformatf("tbl%0d rsp_err", v), 32'(rsp_err), 32'(vecs[v].err));
            step();
            check($sformatf("tbl%0d rsp_valid drop", v), 32'(rsp_valid), 32'd0);
        end

        // Backpressure in RESP.
        rsp_ready  = 1'b0;
        conv_delay = 1;
        set_req(1, 22'h080000);
        wait_accept(1, "bp");
        set_req(3, 22'h040000);
        wait_rsp(e);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_id", k), 32'(rsp_id), 32'd1);
            check($sformatf("bp%0d rsp_result", k), rsp_result, 32'h3F000000);
            check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        check("bp released rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp resume req_ready", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        wait_rsp(e);
        check("bp next rsp_id", 32'(rsp_id), 32'd3);
        check("bp next rsp_result", rsp_result, 32'h3E800000);
        step();

        // Reset during WAIT, with a late done after reset.
        conv_delay = 8;
        set_req(0, 22'h100000);
        wait_accept(0, "rw");
        step();
        step();
        rst = 1'b1;
        #1;
        check("rw in-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw in-reset conv_enable", 32'(conv_enable), 32'd0);
        step();
        step();
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid || conv_enable) seen = 1;
            step();
        end
        check("rw no response after reset", 32'(seen), 32'd0);
        conv_delay = 1;
        set_req(1, 22'h080000);
        set_req(0, 22'h100000);
        #1;
        check("rw pointer reset grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        wait_rsp(e);
        check("rw post-reset rsp_id", 32'(rsp_id), 32'd0);
        check("rw post-reset rsp_result", rsp_result, 32'h3F800000);
        step();

        // Randomized run against a transaction-level model.
        rst = 1'b1;
        step();
        step();
        rst  = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        idle = 1'b1;
        ptr = 0; due = 0; cur_id = 0; cur_d = 0; cur_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 22'($urandom);
                end else if (pend[i] && ($urandom % 16) == 0) begin
                    pend[i] = 1'b0;
                end
                req_data[i*FW +: FW] = pdata[i];
            end
            req_valid = pend;
            rsp_ready = ($urandom % 4) != 0;
            #1;
            g      = idle ? rr_pick(ptr, pend) : -1;
            exp_rv = !idle && cyc >= due;
            check("rnd req_ready", 32'(req_ready), 32'(onehot(g)));
            check("rnd rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("rnd rsp_id", 32'(rsp_id), 32'(cur_id));
                check("rnd rsp_result", rsp_result, (cur_d == 0) ? 32'h0 : fix2float(cur_data));
                check("rnd rsp_err", 32'(rsp_err), 32'(cur_d == 0));
            end
            if (g >= 0) begin
                idle       = 1'b0;
                cur_id     = g;
                cur_data   = pdata[g];
                cur_d      = $urandom_range(0, T);
                conv_delay = cur_d;
                w          = (cur_d == 0) ? T : cur_d;
                due        = cyc + 2 + w;
                ptr        = (g + 1) % N;
                pend[g]    = 1'b0;
            end else if (exp_rv && rsp_ready) begin
                idle = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
